// File: rtl/frame_datagram_builder_if.sv
// Handshake bundle between the frame datagram builder and its consumers:
// build request in, published datagram / update strobe / busy out.
interface frame_datagram_builder_if #(
    parameter int MESSAGE_SIZE = 176
);
    logic                    frame_tick;
    logic [MESSAGE_SIZE-1:0] datagram;
    logic                    datagram_valid;
    logic                    busy;

    modport master (
        input  frame_tick,
        output datagram,
        output datagram_valid,
        output busy
    );

    modport slave (
        output frame_tick,
        input  datagram,
        input  datagram_valid,
        input  busy
    );
endinterface

// File: rtl/frame_datagram_builder.sv
// Builds the per-frame display datagram: snapshot, distance sort of active aliens, atomic publish.
// Optional macro SORT_EARLY_EXIT_EN ends the sort as soon as every active alien has been emitted.
module frame_datagram_builder #(
    parameter int OBJ_LIMIT            = 4,
    parameter int OBJ_COUNT            = OBJ_LIMIT,
    parameter int REC_W                = 35,
    parameter int STATE_SIZE           = 2,
    parameter int LEVEL_SIZE           = 4,
    parameter int SCORE_SIZE           = 16,
    parameter int SCOREBOARD_DATA_SIZE = 64,
    parameter logic [STATE_SIZE-1:0] SCENE_INGAME     = STATE_SIZE'(1),
    parameter logic [STATE_SIZE-1:0] SCENE_SCOREBOARD = STATE_SIZE'(2)
) (
    input  logic                            clk,
    input  logic                            rst,
    frame_datagram_builder_if.master        bus,
    input  logic [STATE_SIZE-1:0]           core_state,
    input  logic [LEVEL_SIZE-1:0]           level,
    input  logic [SCORE_SIZE-1:0]           score,
    input  logic                            laser_active,
    input  logic [3:0]                      laser_r,
    input  logic [8:0]                      laser_deg,
    input  logic [OBJ_COUNT*REC_W-1:0]      obj_in,
    input  logic [SCOREBOARD_DATA_SIZE-1:0] scoreboard_in
);
    localparam int IW           = $clog2(OBJ_COUNT + 1);
    localparam int TABLE_W      = OBJ_COUNT * REC_W;
    localparam int FRAME_W      = 14 + TABLE_W;
    localparam int MESSAGE_SIZE = STATE_SIZE + LEVEL_SIZE + SCORE_SIZE + FRAME_W;
    localparam int SB_PAD       = MESSAGE_SIZE - STATE_SIZE - SCOREBOARD_DATA_SIZE;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic                            pending_q, pending_d;
    logic                            busy_q, busy_d;
    logic                            valid_q, valid_d;
    logic [MESSAGE_SIZE-1:0]         datagram_q, datagram_d;
    logic [STATE_SIZE-1:0]           snap_state_q, snap_state_d;
    logic [LEVEL_SIZE-1:0]           snap_level_q, snap_level_d;
    logic [SCORE_SIZE-1:0]           snap_score_q, snap_score_d;
    logic                            snap_laser_active_q, snap_laser_active_d;
    logic [3:0]                      snap_laser_r_q, snap_laser_r_d;
    logic [8:0]                      snap_laser_deg_q, snap_laser_deg_d;
    logic [TABLE_W-1:0]              snap_obj_q, snap_obj_d;
    logic [SCOREBOARD_DATA_SIZE-1:0] snap_sb_q, snap_sb_d;
    logic [TABLE_W-1:0]              stage_q, stage_d;
    logic [IW-1:0]                   wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic [3:0]                      r_cnt_q, r_cnt_d;
    logic [REC_W-1:0]                rec_s;
    logic                            hit_s;
    logic                            done_s;
`ifdef SORT_EARLY_EXIT_EN
    logic [IW-1:0]                   act_cnt_q, act_cnt_d;

    function automatic logic [IW-1:0] count_active(input logic [TABLE_W-1:0] tbl);
        logic [IW-1:0] n;
        n = {IW{1'b0}};
        for (int k = 0; k < OBJ_COUNT; k++) begin
            n = n + IW'(tbl[k*REC_W]);
        end
        return n;
    endfunction
`endif

    // Next-state, snapshot, sort step and publish logic.
    always_comb begin
        state_d             = state_q;
        pending_d           = pending_q;
        busy_d              = busy_q;
        valid_d             = 1'b0;
        datagram_d          = datagram_q;
        snap_state_d        = snap_state_q;
        snap_level_d        = snap_level_q;
        snap_score_d        = snap_score_q;
        snap_laser_active_d = snap_laser_active_q;
        snap_laser_r_d      = snap_laser_r_q;
        snap_laser_deg_d    = snap_laser_deg_q;
        snap_obj_d          = snap_obj_q;
        snap_sb_d           = snap_sb_q;
        stage_d             = stage_q;
        wr_ptr_d            = wr_ptr_q;
        idx_d               = idx_q;
        r_cnt_d             = r_cnt_q;
`ifdef SORT_EARLY_EXIT_EN
        act_cnt_d           = act_cnt_q;
`endif
        rec_s  = snap_obj_q[int'(idx_q)*REC_W +: REC_W];
        hit_s  = rec_s[0] && (rec_s[8:5] == r_cnt_q);
        done_s = (idx_q == IW'(OBJ_COUNT - 1)) && (r_cnt_q == 4'd15);
`ifdef SORT_EARLY_EXIT_EN
        done_s = done_s || (hit_s && ((wr_ptr_q + IW'(1)) == act_cnt_q));
`endif

        case (state_q)
            IDLE: begin
                // Capture on the tick edge, start the build one cycle later.
                if (pending_q) begin
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    stage_d   = {TABLE_W{1'b0}};
                    wr_ptr_d  = {IW{1'b0}};
                    idx_d     = {IW{1'b0}};
                    r_cnt_d   = 4'd0;
`ifdef SORT_EARLY_EXIT_EN
                    act_cnt_d = count_active(snap_obj_q);
                    if ((snap_state_q == SCENE_INGAME) && (count_active(snap_obj_q) != {IW{1'b0}})) begin
                        state_d = SCAN;
                    end else begin
                        state_d = COMMIT;
                    end
`else
                    if (snap_state_q == SCENE_INGAME) begin
                        state_d = SCAN;
                    end else begin
                        state_d = COMMIT;
                    end
`endif
                end else if (bus.frame_tick) begin
                    pending_d           = 1'b1;
                    snap_state_d        = core_state;
                    snap_level_d        = level;
                    snap_score_d        = score;
                    snap_laser_active_d = laser_active;
                    snap_laser_r_d      = laser_r;
                    snap_laser_deg_d    = laser_deg;
                    snap_obj_d          = obj_in;
                    snap_sb_d           = scoreboard_in;
                end else begin
                    pending_d = 1'b0;
                end
            end

            SCAN: begin
                if (hit_s && (wr_ptr_q < IW'(OBJ_COUNT))) begin
                    stage_d[int'(wr_ptr_q)*REC_W +: REC_W] = rec_s;
                    wr_ptr_d = wr_ptr_q + IW'(1);
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                // One full pass over the table per distance value, closest first.
                if (idx_q == IW'(OBJ_COUNT - 1)) begin
                    idx_d = {IW{1'b0}};
                    if (r_cnt_q != 4'd15) begin
                        r_cnt_d = r_cnt_q + 4'd1;
                    end else begin
                        r_cnt_d = r_cnt_q;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
                if (done_s) begin
                    state_d = COMMIT;
                end else begin
                    state_d = SCAN;
                end
            end

            COMMIT: begin
                if (snap_state_q == SCENE_INGAME) begin
                    datagram_d = {stage_q, snap_laser_deg_q, snap_laser_r_q, snap_laser_active_q,
                                  snap_score_q, snap_level_q, snap_state_q};
                end else if (snap_state_q == SCENE_SCOREBOARD) begin
                    datagram_d = {{SB_PAD{1'b0}}, snap_sb_q, snap_state_q};
                end else begin
                    datagram_d = {{FRAME_W{1'b0}}, snap_score_q, snap_level_q, snap_state_q};
                end
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                pending_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            pending_q           <= 1'b0;
            busy_q              <= 1'b0;
            valid_q             <= 1'b0;
            datagram_q          <= {MESSAGE_SIZE{1'b0}};
            snap_state_q        <= {STATE_SIZE{1'b0}};
            snap_level_q        <= {LEVEL_SIZE{1'b0}};
            snap_score_q        <= {SCORE_SIZE{1'b0}};
            snap_laser_active_q <= 1'b0;
            snap_laser_r_q      <= 4'd0;
            snap_laser_deg_q    <= 9'd0;
            snap_obj_q          <= {TABLE_W{1'b0}};
            snap_sb_q           <= {SCOREBOARD_DATA_SIZE{1'b0}};
            stage_q             <= {TABLE_W{1'b0}};
            wr_ptr_q            <= {IW{1'b0}};
            idx_q               <= {IW{1'b0}};
            r_cnt_q             <= 4'd0;
`ifdef SORT_EARLY_EXIT_EN
            act_cnt_q           <= {IW{1'b0}};
`endif
        end else begin
            state_q             <= state_d;
            pending_q           <= pending_d;
            busy_q              <= busy_d;
            valid_q             <= valid_d;
            datagram_q          <= datagram_d;
            snap_state_q        <= snap_state_d;
            snap_level_q        <= snap_level_d;
            snap_score_q        <= snap_score_d;
            snap_laser_active_q <= snap_laser_active_d;
            snap_laser_r_q      <= snap_laser_r_d;
            snap_laser_deg_q    <= snap_laser_deg_d;
            snap_obj_q          <= snap_obj_d;
            snap_sb_q           <= snap_sb_d;
            stage_q             <= stage_d;
            wr_ptr_q            <= wr_ptr_d;
            idx_q               <= idx_d;
            r_cnt_q             <= r_cnt_d;
`ifdef SORT_EARLY_EXIT_EN
            act_cnt_q           <= act_cnt_d;
`endif
        end
    end

    assign bus.datagram       = datagram_q;
    assign bus.datagram_valid = valid_q;
    assign bus.busy           = busy_q;
endmodule
